mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Shares the single data-memory port and the two timer register files between two requesters: the CPU MEM stage (already-split word address plus byte enables) and a DMA/debug master.
- Decodes the granted address to one of three targets: DM, TIMER0 or TIMER1.
- Routes read data back to the requester.
- Stalls the CPU pipeline for any cycle in which the DMA side owns the bus.
- Guarantees the DMA side a bounded wait.

Parameters:
- MAX_WAIT, 4: cycles a pending DMA request may be refused before it is forced through.
- DATA_LO, 32'h0000_0000: first byte address of DM.
- DATA_HI, 32'h0000_2FFF: last byte address of DM.
- TMR0_BASE, 32'h0000_7F00: TIMER0 base; 3 words.
- TMR1_BASE, 32'h0000_7F10: TIMER1 base; 3 words.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  MEM-stage load/store valid this cycle
- cpu_pc  in  32  PC of the MEM-stage instruction
- cpu_addr  in  30  word address [31:2]
- cpu_we  in  4  byte enables; 0 means read
- cpu_wdata  in  32  pre-shifted store data
- cpu_rdata  out  32  read data, combinational, valid in the grant cycle
- cpu_stall  out  1  CPU lost arbitration this cycle; freeze MEM and all earlier stages
- dma_req  in  1  DMA request; level, held stable until dma_ack
- dma_addr  in  30  word address
- dma_we  in  4  byte enables
- dma_wdata  in  32  write data
- dma_ack  out  1  one-cycle completion pulse
- dma_err  out  1  with dma_ack: address was unmapped or targeted a timer
- dma_rdata  out  32  registered read data, valid while dma_ack=1
- dm_pc  out  32  PC forwarded to DM
- dm_addr  out  30  DM word address
- dm_we  out  4  DM byte enables
- dm_wdata  out  32  DM write data
- dm_rdata  in  32  DM asynchronous read data
- tmr_addr  out  2  timer register index, addr[3:2]
- tmr_wdata  out  32  timer write data
- tmr0_we  out  1  TIMER0 word write
- tmr1_we  out  1  TIMER1 word write
- tmr0_rdata  in  32  TIMER0 read data
- tmr1_rdata  in  32  TIMER1 read data

Behaviour:
- FSM states:
  - IDLE: arbitrates.
  - ACK: dma_ack=1. The DMA side is never granted in ACK; the CPU is granted if it requests. Always returns to IDLE next cycle.
- Grant rule, evaluated combinationally in IDLE only:
  - dma_grant = dma_req && (!cpu_req || wait_cnt >= MAX_WAIT).
  - Otherwise the CPU owns the bus.
  - cpu_stall = cpu_req && dma_grant.
- wait_cnt (3 bits, saturating):
  - Increments when in IDLE with dma_req=1 and dma_grant=0.
  - Clears on dma_grant.
  - Holds otherwise.
- DMA grant cycle:
  - DM is driven from the DMA inputs; dm_pc=0.
  - dma_rdata_q <= dm_rdata.
  - dma_err_q <= address not in [DATA_LO, DATA_HI].
  - If dma_err_q is set, dm_we is forced to 0.
  - Next state is ACK.
  - The DMA master may never write timers; timer accesses set dma_err_q.
- CPU grant cycle (IDLE or ACK with cpu_req=1, no dma_grant):
  - Decode of {addr, 2'b00}:
    - DM range: dm_we = cpu_we.
    - TIMER0 range, words 0-2: tmr0_we = (cpu_we == 4'hF) && addr[3:2] != 2.
    - TIMER1 range: same rule, with tmr1_we.
    - Unmapped: no write.
  - cpu_rdata mux: DM range gives dm_rdata; TIMER0 gives tmr0_rdata; TIMER1 gives tmr1_rdata; unmapped gives 0.
  - Exception filtering is done upstream. This block only suppresses writes; it does not raise exceptions.
- Idle bus (no grant): all we outputs are 0. dm_addr, tmr_addr and wdata outputs follow the CPU inputs, which is harmless because every we is 0.
- Simultaneous requests: the CPU wins until wait_cnt reaches MAX_WAIT, then the DMA wins exactly one cycle.
  - Worst-case DMA latency from dma_req to dma_ack is MAX_WAIT + 2 cycles.
  - The CPU loses at most 1 cycle in every MAX_WAIT + 2.
- A CPU request during ACK is granted with no stall.
- Reset, including mid-transaction:
  - State = IDLE, wait_cnt = 0.
  - dma_ack = 0, dma_err = 0, dma_rdata = 0.
  - An in-flight DMA transaction is dropped; the master re-issues it because its req is still held.
  - All combinational outputs follow the rules above with state = IDLE.
- dma_req falling before dma_ack is a protocol violation; behaviour is undefined.

Decomposition:
- Shared memconfig constants: DATA/TIMER base and end addresses, timer register offsets (CTRL=0, PRESET=1, COUNT=2).
- Shared package: FSM state encodings (ST_IDLE, ST_ACK).
- One natural sub-module, mem_addr_decode: combinational decode of {addr, 2'b00} to one-hot {dm, tmr0, tmr1, none}. It is instantiated twice, once for the CPU path and once for the DMA path.

Test Plan:
- CPU-only store: cpu_req=1, addr=0x10>>2, we=4'hF, wdata=0xDEADBEEF -> dm_we=4'hF and cpu_stall=0 in the same cycle; a following load returns 0xDEADBEEF on cpu_rdata.
- DMA-only read with DM[0x20]=0x1234 -> dma_ack=1 and dma_rdata=0x1234 exactly 1 cycle after the request is seen; dma_err=0.
- Contention: cpu_req held at 1, dma_req=1 from cycle 0 -> CPU granted in cycles 0-3, DMA granted in cycle 4 (cpu_stall=1 only there), dma_ack in cycle 5, CPU granted in cycle 5 with no stall.
- Timer access: CPU sw to 0x7F04 -> tmr0_we=1, tmr_addr=1. CPU sw to 0x7F18 -> tmr1_we=0. CPU lw from 0x7F14 returns tmr1_rdata. DMA read of 0x7F00 -> dma_ack=1, dma_err=1, no timer access.
- Unmapped accesses: DMA write to 0x4000 -> dma_err=1, dm_we stays 0. CPU lw from 0x5000 -> cpu_rdata=0, all we=0.
- Reset mid-grant: assert reset in the DMA grant cycle -> next cycle dma_ack=0 and state IDLE; with dma_req still held, the DMA is re-granted and acked correctly after reset releases.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: FSM encodings, the memory
// map used by the address decoders, and timer register offsets.
package mem_bus_arbiter_pkg;

    // Arbiter FSM: IDLE arbitrates, ACK presents the one-cycle DMA completion.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } arb_state_t;

    // Default memory map (byte addresses).
    localparam logic [31:0] MAP_DATA_LO   = 32'h0000_0000;
    localparam logic [31:0] MAP_DATA_HI   = 32'h0000_2FFF;
    localparam logic [31:0] MAP_TMR0_BASE = 32'h0000_7F00;
    localparam logic [31:0] MAP_TMR1_BASE = 32'h0000_7F10;

    // Each timer exposes three word registers starting at its base.
    localparam int unsigned TMR_WORDS = 3;

    // Timer register word offsets (addr[3:2]); COUNT is read-only.
    localparam logic [1:0] TMR_REG_CTRL   = 2'd0;
    localparam logic [1:0] TMR_REG_PRESET = 2'd1;
    localparam logic [1:0] TMR_REG_COUNT  = 2'd2;

    // One-hot decode result.
    typedef struct packed {
        logic dm;
        logic tmr0;
        logic tmr1;
        logic none;
    } tgt_t;

    // Inclusive window test written as an offset compare so that a window
    // starting at address 0 does not produce an always-true comparison.
    function automatic logic in_window(input logic [31:0] byte_addr,
                                       input logic [31:0] first,
                                       input logic [31:0] last);
        return (byte_addr - first) <= (last - first);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_decode.sv
// Combinational decode of a word address to one of DM, TIMER0, TIMER1 or
// unmapped. Exactly one bit of the result is set.
module mem_addr_decode
    import mem_bus_arbiter_pkg::*;
#(
    parameter logic [31:0] DATA_LO   = MAP_DATA_LO,
    parameter logic [31:0] DATA_HI   = MAP_DATA_HI,
    parameter logic [31:0] TMR0_BASE = MAP_TMR0_BASE,
    parameter logic [31:0] TMR1_BASE = MAP_TMR1_BASE
) (
    input  logic [29:0] addr,
    output tgt_t        tgt
);

    localparam logic [31:0] TMR_SPAN = 32'(4 * TMR_WORDS) - 32'd1;

    logic [31:0] byte_addr;
    logic        hit_dm;
    logic        hit_tmr0;
    logic        hit_tmr1;

    assign byte_addr = {addr, 2'b00};

    // Window hits, then priority-resolve so the result is one-hot even if
    // a future map overlaps regions.
    always_comb begin
        hit_dm   = in_window(byte_addr, DATA_LO, DATA_HI);
        hit_tmr0 = in_window(byte_addr, TMR0_BASE, TMR0_BASE + TMR_SPAN);
        hit_tmr1 = in_window(byte_addr, TMR1_BASE, TMR1_BASE + TMR_SPAN);

        tgt      = '0;
        tgt.dm   = hit_dm;
        tgt.tmr0 = !hit_dm && hit_tmr0;
        tgt.tmr1 = !hit_dm && !hit_tmr0 && hit_tmr1;
        tgt.none = !hit_dm && !hit_tmr0 && !hit_tmr1;
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the data-memory port and the two timer register files between
// the CPU MEM stage and a DMA/debug master. The CPU has priority, but a
// pending DMA request is forced through after MAX_WAIT refusals.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | arbitrate; DMA granted on free bus or when wait_cnt expired
// ST_ACK   | dma_ack=1 for the transfer granted last cycle; CPU may use bus
//
// MAX_WAIT must fit the 3-bit saturating wait counter (0..7).
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT  = 4,
    parameter logic [31:0] DATA_LO   = MAP_DATA_LO,
    parameter logic [31:0] DATA_HI   = MAP_DATA_HI,
    parameter logic [31:0] TMR0_BASE = MAP_TMR0_BASE,
    parameter logic [31:0] TMR1_BASE = MAP_TMR1_BASE
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        cpu_req,
    input  logic [31:0] cpu_pc,
    input  logic [29:0] cpu_addr,
    input  logic [3:0]  cpu_we,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,

    input  logic        dma_req,
    input  logic [29:0] dma_addr,
    input  logic [3:0]  dma_we,
    input  logic [31:0] dma_wdata,
    output logic        dma_ack,
    output logic        dma_err,
    output logic [31:0] dma_rdata,

    output logic [31:0] dm_pc,
    output logic [29:0] dm_addr,
    output logic [3:0]  dm_we,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,

    output logic [1:0]  tmr_addr,
    output logic [31:0] tmr_wdata,
    output logic        tmr0_we,
    output logic        tmr1_we,
    input  logic [31:0] tmr0_rdata,
    input  logic [31:0] tmr1_rdata
);

    localparam logic [2:0] MAX_WAIT_C = 3'(MAX_WAIT);

    arb_state_t  state;
    arb_state_t  state_nxt;
    logic [2:0]  wait_cnt;
    logic [2:0]  wait_cnt_nxt;
    logic        dma_err_q;
    logic [31:0] dma_rdata_q;

    logic        dma_grant;
    logic        cpu_grant;
    logic        dma_bad_addr;
    logic        tmr_wr_ok;

    tgt_t        cpu_tgt;
    tgt_t        dma_tgt;

    mem_addr_decode #(
        .DATA_LO   (DATA_LO),
        .DATA_HI   (DATA_HI),
        .TMR0_BASE (TMR0_BASE),
        .TMR1_BASE (TMR1_BASE)
    ) u_cpu_decode (
        .addr (cpu_addr),
        .tgt  (cpu_tgt)
    );

    mem_addr_decode #(
        .DATA_LO   (DATA_LO),
        .DATA_HI   (DATA_HI),
        .TMR0_BASE (TMR0_BASE),
        .TMR1_BASE (TMR1_BASE)
    ) u_dma_decode (
        .addr (dma_addr),
        .tgt  (dma_tgt)
    );

    // The DMA master may only touch DM; timer or unmapped targets are errors.
    assign dma_bad_addr = dma_tgt.none || dma_tgt.tmr0 || dma_tgt.tmr1;

    // Timer writes must be full-word and must not hit the read-only COUNT.
    assign tmr_wr_ok = (cpu_we == 4'hF) && (cpu_addr[1:0] != TMR_REG_COUNT);

    // State, wait counter and captured DMA response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            wait_cnt    <= 3'd0;
            dma_err_q   <= 1'b0;
            dma_rdata_q <= 32'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (dma_grant) begin
                dma_err_q   <= dma_bad_addr;
                dma_rdata_q <= dm_rdata;
            end
        end
    end

    // Grant decision, next state and wait-counter update.
    always_comb begin
        dma_grant    = 1'b0;
        cpu_grant    = 1'b0;
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;

        unique case (state)
            ST_IDLE: begin
                dma_grant = dma_req && (!cpu_req || (wait_cnt >= MAX_WAIT_C));
                cpu_grant = cpu_req && !dma_grant;
                if (dma_grant) begin
                    state_nxt    = ST_ACK;
                    wait_cnt_nxt = 3'd0;
                end else if (dma_req && (wait_cnt != 3'd7)) begin
                    wait_cnt_nxt = wait_cnt + 3'd1;
                end
            end
            ST_ACK: begin
                cpu_grant = cpu_req;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Bus steering: idle bus follows the CPU with every write enable low.
    always_comb begin
        dm_pc     = cpu_pc;
        dm_addr   = cpu_addr;
        dm_wdata  = cpu_wdata;
        dm_we     = 4'h0;
        tmr_addr  = cpu_addr[1:0];
        tmr_wdata = cpu_wdata;
        tmr0_we   = 1'b0;
        tmr1_we   = 1'b0;
        cpu_rdata = 32'd0;

        if (dma_grant) begin
            dm_pc     = 32'd0;
            dm_addr   = dma_addr;
            dm_wdata  = dma_wdata;
            dm_we     = dma_bad_addr ? 4'h0 : dma_we;
            tmr_addr  = dma_addr[1:0];
            tmr_wdata = dma_wdata;
        end else if (cpu_grant) begin
            dm_we   = cpu_tgt.dm ? cpu_we : 4'h0;
            tmr0_we = cpu_tgt.tmr0 && tmr_wr_ok;
            tmr1_we = cpu_tgt.tmr1 && tmr_wr_ok;
            unique case (1'b1)
                cpu_tgt.dm:   cpu_rdata = dm_rdata;
                cpu_tgt.tmr0: cpu_rdata = tmr0_rdata;
                cpu_tgt.tmr1: cpu_rdata = tmr1_rdata;
                cpu_tgt.none: cpu_rdata = 32'd0;
                default:      cpu_rdata = 32'd0;
            endcase
        end
    end

    assign cpu_stall = cpu_req && dma_grant;
    assign dma_ack   = (state == ST_ACK);
    assign dma_err   = dma_ack && dma_err_q;
    assign dma_rdata = dma_rdata_q;

endmodule
